// File: rtl/apb_slave_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : apb_slave_pkg
// | Brief    : Shared types and defaults for the APB register-memory slave.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
package apb_slave_pkg;

    localparam int DEF_AWIDTH = 8;
    localparam int DEF_DWIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10
    } state_t;

    // Index width for a memory of the given depth (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : apb_slave_pkg
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : apb_slave_mem
// | Brief    : MEM_DEPTH x DWIDTH array, synchronous write, registered read.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
module apb_slave_mem #(
    parameter int DWIDTH    = 32,
    parameter int MEM_DEPTH = 256,
    parameter int IDX_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              rzero,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] r_mem [MEM_DEPTH];

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    // Read register only updates on a completed read, so it holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : r_mem[idx];
        end
    end

endmodule : apb_slave_mem
`default_nettype wire

// File: rtl/apb_slave.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : apb_slave
// | Brief    : APB-style slave over a word-addressed register memory.
// |            Define APB_SLAVE_PSLVERR_EN to add the p_slverr error output.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
module apb_slave
    import apb_slave_pkg::*;
#(
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    input  logic              p_sel,
    input  logic              p_en,
    input  logic              p_write,
`ifdef APB_SLAVE_PSLVERR_EN
    output logic              p_slverr,
`endif
    output logic              p_ready
);

    localparam int                c_idx_w = idx_width(MEM_DEPTH);
    localparam logic [AWIDTH:0]   c_depth = (AWIDTH+1)'(MEM_DEPTH);

    state_t r_state;
    logic   w_in_range;
    logic   w_access;
    logic   w_we;
    logic   w_re;

    assign w_in_range = ({1'b0, addr} < c_depth);
    assign w_access   = ((r_state == WRITE) || (r_state == READ)) && p_sel && p_en;
    assign w_we       = w_access && (r_state == WRITE) && w_in_range;
    assign w_re       = w_access && (r_state == READ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            p_ready  <= 1'b0;
`ifdef APB_SLAVE_PSLVERR_EN
            p_slverr <= 1'b0;
`endif
        end else begin
            p_ready  <= 1'b0;
`ifdef APB_SLAVE_PSLVERR_EN
            p_slverr <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (p_sel) begin
                        r_state <= p_write ? WRITE : READ;
                    end
                end
                WRITE, READ: begin
                    if (!p_sel) begin
                        r_state <= IDLE;
                    end else if (p_en) begin
                        p_ready  <= 1'b1;
`ifdef APB_SLAVE_PSLVERR_EN
                        p_slverr <= !w_in_range;
`endif
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to IDLE and flag it.
                    r_state  <= IDLE;
`ifdef APB_SLAVE_PSLVERR_EN
                    p_slverr <= 1'b1;
`endif
                end
            endcase
        end
    end

    apb_slave_mem #(
        .DWIDTH    (DWIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (c_idx_w)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we),
        .re    (w_re),
        .rzero (!w_in_range),
        .idx   (addr[c_idx_w-1:0]),
        .wdata (wdata),
        .rdata (rdata)
    );

endmodule : apb_slave
`default_nettype wire

// File: tb/tb_apb_slave.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : tb_apb_slave
// | Brief    : Self-checking bench for apb_slave against a word-array model.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
module tb_apb_slave;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          p_sel;
    logic          p_en;
    logic          p_write;
    logic          p_ready;
    logic          p_slverr;

    int checks = 0;
    int passes = 0;

    logic [DW-1:0] model_mem [0:255];
    logic [DW-1:0] rdata_exp;

    always #5 clk = ~clk;

    apb_slave #(
        .AWIDTH    (AW),
        .DWIDTH    (DW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .p_sel    (p_sel),
        .p_en     (p_en),
        .p_write  (p_write),
`ifdef APB_SLAVE_PSLVERR_EN
        .p_slverr (p_slverr),
`endif
        .p_ready  (p_ready)
    );

`ifndef APB_SLAVE_PSLVERR_EN
    assign p_slverr = 1'b0;
`endif

    // Bus driver: setup cycle, optional wait cycles, then access cycle.
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int waits, output logic early, output logic done,
                            output logic [DW-1:0] rd, output logic err);
        early = 1'b0;
        p_sel = 1'b1; p_en = 1'b0; p_write = wr; addr = a; wdata = d;
        @(posedge clk); #1; early |= p_ready;
        repeat (waits) begin
            @(posedge clk); #1; early |= p_ready;
        end
        p_en = 1'b1;
        @(posedge clk); #1;
        done = p_ready; rd = rdata; err = p_slverr;
        p_sel = 1'b0; p_en = 1'b0;
    endtask

    task automatic test_reset();
        logic e, dn, er;
        logic [DW-1:0] rd;
        rst = 1'b1; p_sel = 0; p_en = 0; p_write = 0; addr = '0; wdata = '0;
        @(posedge clk); #1;
        checks++; if (rdata !== '0) $display("FAIL reset_rdata got %h want 0", rdata); else passes++;
        checks++; if (p_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", p_ready); else passes++;
        rst = 1'b0;
        rdata_exp = '0;
        apb_xfer(1'b1, 8'd5, 32'hAAAA_5555, 0, e, dn, rd, er);
        model_mem[5] = 32'hAAAA_5555;
        apb_xfer(1'b0, 8'd5, '0, 0, e, dn, rd, er);
        checks++; if (rd !== 32'hAAAA_5555) $display("FAIL pre_reset_read got %h want aaaa5555", rd); else passes++;
        // Assert reset mid-cycle during the access phase of a write.
        p_sel = 1; p_en = 0; p_write = 1; addr = 8'd5; wdata = 32'h1234;
        @(posedge clk); #1;
        p_en = 1;
        #2; rst = 1'b1; #1;
        checks++; if (rdata !== '0) $display("FAIL async_reset_rdata got %h want 0", rdata); else passes++;
        checks++; if (p_ready !== 1'b0) $display("FAIL async_reset_ready got %b want 0", p_ready); else passes++;
        rdata_exp = '0;
        @(posedge clk); #1;
        rst = 1'b0; p_sel = 0; p_en = 0;
        apb_xfer(1'b0, 8'd5, '0, 0, e, dn, rd, er);
        rdata_exp = model_mem[5];
        checks++; if (e !== 1'b0 || dn !== 1'b1) $display("FAIL post_reset_handshake got early=%b done=%b want 0/1", e, dn); else passes++;
        checks++; if (rd !== rdata_exp) $display("FAIL reset_aborts_write got %h want %h", rd, rdata_exp); else passes++;
    endtask

    task automatic test_write_sweep();
        p_sel = 1; p_en = 1; p_write = 1;
        for (int i = 0; i < 10; i++) begin
            addr = AW'(i); wdata = DW'(2 * i);
            @(posedge clk); #1;
            checks++; if (p_ready !== 1'b0) $display("FAIL wsweep_setup[%0d] ready got %b want 0", i, p_ready); else passes++;
            @(posedge clk); #1;
            model_mem[i] = DW'(2 * i);
            checks++; if (p_ready !== 1'b1) $display("FAIL wsweep_done[%0d] ready got %b want 1", i, p_ready); else passes++;
            checks++; if (rdata !== rdata_exp) $display("FAIL wsweep_rdata_hold[%0d] got %h want %h", i, rdata, rdata_exp); else passes++;
        end
        p_sel = 0; p_en = 0;
    endtask

    task automatic test_read_sweep();
        p_sel = 1; p_en = 1; p_write = 0;
        for (int i = 0; i < 10; i++) begin
            addr = AW'(i);
            @(posedge clk); #1;
            checks++; if (p_ready !== 1'b0) $display("FAIL rsweep_setup[%0d] ready got %b want 0", i, p_ready); else passes++;
            @(posedge clk); #1;
            rdata_exp = DW'(2 * i);
            checks++; if (p_ready !== 1'b1) $display("FAIL rsweep_done[%0d] ready got %b want 1", i, p_ready); else passes++;
            checks++; if (rdata !== rdata_exp) $display("FAIL rsweep_rdata[%0d] got %h want %h", i, rdata, rdata_exp); else passes++;
        end
        p_sel = 0; p_en = 0;
    endtask

    task automatic test_single_access();
        logic e, dn, er;
        logic [DW-1:0] rd;
        apb_xfer(1'b1, 8'd23, 32'd55, 0, e, dn, rd, er);
        model_mem[23] = 32'd55;
        checks++; if (dn !== 1'b1) $display("FAIL single_write_ready got %b want 1", dn); else passes++;
        apb_xfer(1'b0, 8'd23, '0, 0, e, dn, rd, er);
        rdata_exp = 32'd55;
        checks++; if (rd !== rdata_exp) $display("FAIL single_read got %h want %h", rd, rdata_exp); else passes++;
    endtask

    task automatic test_wait_state();
        logic e, dn, er;
        logic [DW-1:0] rd;
        p_sel = 1; p_en = 0; p_write = 1; addr = 8'd40; wdata = $urandom;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            wdata = $urandom;
            @(posedge clk); #1;
            checks++; if (p_ready !== 1'b0) $display("FAIL wait_ready[%0d] got %b want 0", i, p_ready); else passes++;
        end
        p_en = 1; wdata = 32'hC0DE_0040;
        @(posedge clk); #1;
        model_mem[40] = 32'hC0DE_0040;
        checks++; if (p_ready !== 1'b1) $display("FAIL wait_complete got %b want 1", p_ready); else passes++;
        p_sel = 0; p_en = 0;
        apb_xfer(1'b0, 8'd40, '0, 0, e, dn, rd, er);
        rdata_exp = model_mem[40];
        checks++; if (rd !== rdata_exp) $display("FAIL wait_readback got %h want %h", rd, rdata_exp); else passes++;
    endtask

    task automatic test_abort();
        logic e, dn, er;
        logic [DW-1:0] rd;
        p_sel = 1; p_en = 0; p_write = 0; addr = 8'd2;
        @(posedge clk); #1;
        p_sel = 0;
        @(posedge clk); #1;
        checks++; if (p_ready !== 1'b0) $display("FAIL abort_read_ready got %b want 0", p_ready); else passes++;
        checks++; if (rdata !== rdata_exp) $display("FAIL abort_read_rdata got %h want %h", rdata, rdata_exp); else passes++;
        p_sel = 1; p_en = 0; p_write = 1; addr = 8'd23; wdata = 32'd999;
        @(posedge clk); #1;
        p_sel = 0; p_en = 1;
        @(posedge clk); #1;
        p_en = 0;
        checks++; if (p_ready !== 1'b0) $display("FAIL abort_write_ready got %b want 0", p_ready); else passes++;
        apb_xfer(1'b0, 8'd23, '0, 0, e, dn, rd, er);
        rdata_exp = model_mem[23];
        checks++; if (e !== 1'b0 || dn !== 1'b1) $display("FAIL abort_then_idle got early=%b done=%b want 0/1", e, dn); else passes++;
        checks++; if (rd !== rdata_exp) $display("FAIL abort_no_write got %h want %h", rd, rdata_exp); else passes++;
    endtask

    task automatic test_boundary();
        logic e, dn, er;
        logic [DW-1:0] rd;
        apb_xfer(1'b1, 8'd127, 32'h7F7F_7F7F, 0, e, dn, rd, er);
        model_mem[127] = 32'h7F7F_7F7F;
        checks++; if (er !== 1'b0) $display("FAIL bound_127_err got %b want 0", er); else passes++;
        apb_xfer(1'b1, 8'd128, 32'hBAD0_0128, 0, e, dn, rd, er);
        checks++; if (dn !== 1'b1) $display("FAIL bound_128_write_ready got %b want 1", dn); else passes++;
`ifdef APB_SLAVE_PSLVERR_EN
        checks++; if (er !== 1'b1) $display("FAIL bound_128_err got %b want 1", er); else passes++;
`endif
        apb_xfer(1'b0, 8'd0, '0, 0, e, dn, rd, er);
        rdata_exp = model_mem[0];
        checks++; if (rd !== rdata_exp) $display("FAIL bound_no_alias got %h want %h", rd, rdata_exp); else passes++;
        apb_xfer(1'b0, 8'd127, '0, 0, e, dn, rd, er);
        rdata_exp = model_mem[127];
        checks++; if (rd !== rdata_exp) $display("FAIL bound_127_read got %h want %h", rd, rdata_exp); else passes++;
        apb_xfer(1'b0, 8'd255, '0, 0, e, dn, rd, er);
        rdata_exp = '0;
        checks++; if (rd !== rdata_exp) $display("FAIL bound_255_read got %h want 0", rd); else passes++;
`ifdef APB_SLAVE_PSLVERR_EN
        checks++; if (er !== 1'b1) $display("FAIL bound_255_err got %b want 1", er); else passes++;
`endif
    endtask

    task automatic test_random();
        logic e, dn, er;
        logic [DW-1:0] rd, d;
        logic [AW-1:0] a;
        logic wr;
        int waits;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            apb_xfer(1'b1, AW'(i), d, 0, e, dn, rd, er);
            model_mem[i] = d;
        end
        for (int n = 0; n < 80; n++) begin
            wr = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 255));
            d = $urandom;
            waits = $urandom_range(0, 2);
            apb_xfer(wr, a, d, waits, e, dn, rd, er);
            if (wr) begin
                if (int'(a) < DEPTH) model_mem[a] = d;
            end else begin
                rdata_exp = (int'(a) < DEPTH) ? model_mem[a] : '0;
            end
            checks++;
            if (e !== 1'b0 || dn !== 1'b1)
                $display("FAIL rand_handshake[%0d] got early=%b done=%b want 0/1", n, e, dn);
            else passes++;
            checks++;
            if (rd !== rdata_exp)
                $display("FAIL rand_rdata[%0d] wr=%b addr=%0d got %h want %h", n, wr, a, rd, rdata_exp);
            else passes++;
`ifdef APB_SLAVE_PSLVERR_EN
            checks++;
            if (er !== (int'(a) >= DEPTH))
                $display("FAIL rand_slverr[%0d] addr=%0d got %b", n, a, er);
            else passes++;
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_sweep();
        test_read_sweep();
        test_single_access();
        test_wait_state();
        test_abort();
        test_boundary();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_apb_slave
`default_nettype wire
